// File: rtl/ram_responder.sv
// ram_responder: single-port word RAM with a held-request read handshake and fixed read latency.
// Optional macro RAM_RESPONDER_CLEAR_EN zero-fills the memory after every reset (CLEAR state).
`default_nettype none

module ram_responder #(
   parameter int ramWidth    = 8,
   parameter int addrSize    = 8,
   parameter int readLatency = 3
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                RAMreadEnable,
   input  logic                RAMwriteEnable,
   input  logic [addrSize-1:0] addr,
   input  logic [ramWidth-1:0] dataIn,
   output logic [ramWidth-1:0] dataOut,
   output logic                dataReady,
   output logic                busy,
   output logic                protoErr
);

   localparam int         c_DEPTH  = 1 << addrSize;
   localparam logic [3:0] c_LAT_M1 = 4'(readLatency - 1);

   typedef enum logic [3:0] {
      IDLE      = 4'b0001,
      READ_WAIT = 4'b0010,
      READ_DONE = 4'b0100
`ifdef RAM_RESPONDER_CLEAR_EN
      ,
      CLEAR     = 4'b1000
`endif
   } state_t;

   state_t                state_q;
   logic [3:0]            cnt_q;
   logic [addrSize-1:0]   rdAddr_q;
   logic [ramWidth-1:0]   dataOut_q;
   logic                  dataReady_q;
   logic                  busy_q;
   logic                  protoErr_q;
   logic                  armed_q;
   logic [ramWidth-1:0]   mem_q [c_DEPTH];
`ifdef RAM_RESPONDER_CLEAR_EN
   logic [addrSize-1:0]   clrAddr_q;
`endif

   // Memory port: clear sweep has priority, otherwise the write strobe is honoured in every state.
   always_ff @(posedge clk) begin
`ifdef RAM_RESPONDER_CLEAR_EN
      if (state_q == CLEAR) begin
         mem_q[clrAddr_q] <= '0;
      end else
`endif
      if (RAMwriteEnable) begin
         mem_q[addr] <= dataIn;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q       <= 4'd0;
         rdAddr_q    <= '0;
         dataOut_q   <= '0;
         dataReady_q <= 1'b0;
         protoErr_q  <= 1'b0;
         armed_q     <= 1'b1;
`ifdef RAM_RESPONDER_CLEAR_EN
         state_q     <= CLEAR;
         busy_q      <= 1'b1;
         clrAddr_q   <= '0;
`else
         state_q     <= IDLE;
         busy_q      <= 1'b0;
`endif
      end else begin
         dataReady_q <= 1'b0;
         // A request still held after completion must drop before another can be accepted.
         if (!RAMreadEnable) begin
            armed_q <= 1'b1;
         end
         case (state_q)
            IDLE: begin
               if (RAMreadEnable && armed_q) begin
                  rdAddr_q <= addr;
                  cnt_q    <= c_LAT_M1;
                  busy_q   <= 1'b1;
                  if (readLatency == 1) begin
                     dataOut_q   <= mem_q[addr];
                     dataReady_q <= 1'b1;
                     armed_q     <= 1'b0;
                     state_q     <= READ_DONE;
                  end else begin
                     state_q <= READ_WAIT;
                  end
               end
            end
            READ_WAIT: begin
               if (!RAMreadEnable) begin
                  protoErr_q <= 1'b1;
                  busy_q     <= 1'b0;
                  state_q    <= IDLE;
               end else if (cnt_q == 4'd0) begin
                  dataOut_q   <= mem_q[rdAddr_q];
                  dataReady_q <= 1'b1;
                  armed_q     <= 1'b0;
                  state_q     <= READ_DONE;
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            READ_DONE: begin
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
`ifdef RAM_RESPONDER_CLEAR_EN
            CLEAR: begin
               clrAddr_q <= clrAddr_q + 1'b1;
               if (&clrAddr_q) begin
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end
            end
`endif
            default: begin
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign dataOut   = dataOut_q;
   assign dataReady = dataReady_q;
   assign busy      = busy_q;
   assign protoErr  = protoErr_q;

endmodule

`default_nettype wire

// File: tb/tb_ram_responder.sv
// tb_ram_responder: vector table, directed corner sequences and randomized transactions against a
// transaction-level memory model.
`default_nettype none

module tb_ram_responder;

   localparam int LAT = 3;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       ren = 1'b0;
   logic       we = 1'b0;
   logic [7:0] addr = 8'h00;
   logic [7:0] din = 8'h00;
   logic [7:0] dout;
   logic       drdy;
   logic       busy;
   logic       perr;

   int checks = 0;
   int failures = 0;

   // Reference model: memory image, which words are known, last completed read, sticky error.
   logic [7:0] m_mem [256];
   bit         m_val [256];
   logic [7:0] m_dout;
   bit         m_perr;

   typedef struct {
      bit         is_wr;
      logic [7:0] a;
      logic [7:0] d;
      logic [7:0] exp;
   } vec_t;

   vec_t tbl [8];

   ram_responder #(.ramWidth(8), .addrSize(8), .readLatency(LAT)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .RAMreadEnable (ren),
      .RAMwriteEnable(we),
      .addr          (addr),
      .dataIn        (din),
      .dataOut       (dout),
      .dataReady     (drdy),
      .busy          (busy),
      .protoErr      (perr)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
      end
   endtask

   task automatic do_reset();
      int n;
      rst_n = 1'b0; ren = 1'b0; we = 1'b0;
      tick();
      m_perr = 1'b0;
      m_dout = 8'h00;
      check("rst_dout", dout, 0);
      check("rst_drdy", drdy, 0);
      check("rst_perr", perr, 0);
`ifdef RAM_RESPONDER_CLEAR_EN
      check("rst_busy", busy, 1);
      rst_n = 1'b1;
      n = 0;
      while (busy && n < 400) begin
         tick();
         n++;
      end
      check("clear_len", n, 256);
      for (int i = 0; i < 256; i++) begin
         m_mem[i] = 8'h00;
         m_val[i] = 1'b1;
      end
`else
      check("rst_busy", busy, 0);
      rst_n = 1'b1;
      n = 0;
`endif
   endtask

   task automatic wr(input logic [7:0] a, input logic [7:0] d);
      we = 1'b1; addr = a; din = d;
      tick();
      m_mem[a] = d;
      m_val[a] = 1'b1;
      we = 1'b0;
      check("wr_drdy", drdy, 0);
      check("wr_busy", busy, 0);
   endtask

   // Step s=0 is the acceptance edge, s=LAT the completion edge; one optional write at step wr_at,
   // optional drop of the request before step abort_at, and hold extra cycles of request after completion.
   task automatic rd(input logic [7:0] a, input int wr_at, input logic [7:0] wa, input logic [7:0] wd,
                     input int abort_at, input int hold);
      logic [7:0] exp_d;
      ren = 1'b1;
      for (int s = 0; s <= LAT; s++) begin
         if (s == abort_at) ren = 1'b0;
         if (s == wr_at) begin
            we = 1'b1; din = wd;
            addr = (s == 0) ? a : wa;
         end else begin
            we = 1'b0;
            addr = (s == 0) ? a : 8'($urandom);
         end
         exp_d = m_mem[a];
         tick();
         if (we) begin
            m_mem[addr] = din;
            m_val[addr] = 1'b1;
         end
         we = 1'b0;
         if (s == abort_at) begin
            m_perr = 1'b1;
            check("abort_drdy", drdy, 0);
            check("abort_busy", busy, 0);
            check("abort_perr", perr, 1);
            check("abort_dout", dout, m_dout);
            return;
         end else if (s < LAT) begin
            check("wait_drdy", drdy, 0);
            check("wait_busy", busy, 1);
            check("wait_perr", perr, m_perr);
         end else begin
            m_dout = exp_d;
            check("done_drdy", drdy, 1);
            check("done_dout", dout, m_dout);
            check("done_busy", busy, 1);
         end
      end
      for (int h = 0; h < hold; h++) begin
         tick();
         check("hold_drdy", drdy, 0);
         check("hold_busy", busy, 0);
      end
      ren = 1'b0;
      tick();
      check("post_drdy", drdy, 0);
      check("post_busy", busy, 0);
      check("post_perr", perr, m_perr);
      check("post_dout", dout, m_dout);
   endtask

   initial begin
      tbl[0] = '{1'b1, 8'h10, 8'hA5, 8'h00};
      tbl[1] = '{1'b0, 8'h10, 8'h00, 8'hA5};
      tbl[2] = '{1'b1, 8'hFF, 8'h3C, 8'h00};
      tbl[3] = '{1'b1, 8'h00, 8'h01, 8'h00};
      tbl[4] = '{1'b0, 8'hFF, 8'h00, 8'h3C};
      tbl[5] = '{1'b0, 8'h00, 8'h00, 8'h01};
      tbl[6] = '{1'b1, 8'h10, 8'h5A, 8'h00};
      tbl[7] = '{1'b0, 8'h10, 8'h00, 8'h5A};

      for (int i = 0; i < 256; i++) begin
         m_mem[i] = 8'h00;
         m_val[i] = 1'b0;
      end

      tick();
      do_reset();

      foreach (tbl[i]) begin
         if (tbl[i].is_wr) begin
            wr(tbl[i].a, tbl[i].d);
         end else begin
            rd(tbl[i].a, -1, 8'h00, 8'h00, -1, 0);
            check("tbl_dout", dout, tbl[i].exp);
         end
      end

      // Request held past completion: a single pulse and no re-acceptance.
      rd(8'h10, -1, 8'h00, 8'h00, -1, 2);

      // Request dropped one cycle after acceptance.
      rd(8'hFF, -1, 8'h00, 8'h00, 1, 0);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("sticky_perr", perr, 1);
         check("sticky_drdy", drdy, 0);
         check("sticky_dout", dout, 8'h5A);
      end

      // Read-before-write on the completion edge.
      wr(8'h20, 8'h11);
      rd(8'h20, LAT, 8'h20, 8'h22, -1, 0);
      check("rbw_old", dout, 8'h11);
      rd(8'h20, -1, 8'h00, 8'h00, -1, 0);
      check("rbw_new", dout, 8'h22);

      // Write and read together in IDLE share the address.
      rd(8'h33, 0, 8'h33, 8'h77, -1, 0);
      check("wr_rd_same", dout, 8'h77);

      // Reset in the middle of a read.
      ren = 1'b1; addr = 8'h10;
      tick();
      tick();
      check("pre_rst_busy", busy, 1);
      do_reset();
      for (int i = 0; i < 4; i++) begin
         tick();
         check("after_rst_drdy", drdy, 0);
      end
      rd(8'h10, -1, 8'h00, 8'h00, -1, 0);

      // Randomized transactions.
      for (int t = 0; t < 150; t++) begin
         int op;
         logic [7:0] a;
         a = 8'($urandom);
         op = int'($urandom_range(0, 2));
         if (op == 0) begin
            wr(a, 8'($urandom));
         end else begin
            int wat;
            int abt;
            logic [7:0] wa;
            if (!m_val[a]) wr(a, 8'($urandom));
            wat = int'($urandom_range(0, 4)) - 1;
            wa = ($urandom_range(0, 3) == 0) ? a : 8'($urandom);
            abt = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, LAT)) : -1;
            rd(a, wat, wa, 8'($urandom), abt, int'($urandom_range(0, 2)));
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/ram_responder.md
RAM_RESPONDER -- requirements
Module: ram_responder

Interface
REQ-001 Parameter ramWidth, default 8, data word width in bits.
REQ-002 Parameter addrSize, default 8, address width in bits; depth is 2^addrSize words.
REQ-003 Parameter readLatency, default 3, range 1..15, edges from read acceptance to dataReady assertion.
REQ-004 clk  input  1  sole clock; all state changes on posedge clk.
REQ-005 rst_n  input  1  reset, synchronous and active-low.
REQ-006 RAMreadEnable  input  1  read request, held high by the initiator until dataReady is seen.
REQ-007 RAMwriteEnable  input  1  write strobe, single-cycle, no handshake.
REQ-008 addr  input  addrSize  word address for read or write.
REQ-009 dataIn  input  ramWidth  write data.
REQ-010 dataOut  output  ramWidth  registered read data; holds its value until the next read completes.
REQ-011 dataReady  output  1  registered read-completion flag, high for exactly one cycle per completed read.
REQ-012 busy  output  1  registered; high while in CLEAR, READ_WAIT or READ_DONE.
REQ-013 protoErr  output  1  registered sticky flag for an aborted read.

Function
REQ-014 The FSM SHALL have the states IDLE, READ_WAIT, READ_DONE and, with the macro, CLEAR; encoding is one-hot.
REQ-015 IDLE, RAMreadEnable=1 at edge k: latch addr into rdAddr, load the counter with readLatency-1, go to READ_WAIT (or directly to READ_DONE when readLatency=1).
REQ-016 READ_WAIT: decrement the counter each edge; at the edge where the counter is 0 and RAMreadEnable=1, load dataOut from mem[rdAddr] and go to READ_DONE; dataReady is high from edge k+readLatency.
REQ-017 READ_DONE: dataReady=1 for one cycle; the next edge goes unconditionally to IDLE with dataReady=0, so a request still held over that edge is not re-accepted.
REQ-018 RAMreadEnable=0 sampled in READ_WAIT: go to IDLE, set protoErr=1, do not assert dataReady, leave dataOut unchanged.
REQ-019 RAMwriteEnable=1 at any edge outside CLEAR: mem[addr] takes dataIn at that edge, in any state, with no effect on the FSM.
REQ-020 A write and a read completion to the same address on the same edge: dataOut takes the old word (read-before-write); later reads return the new word.
REQ-021 Read and write requests together in IDLE: perform the write and accept the read at the same edge, capturing addr once for both.
REQ-022 The read latency counter SHALL be 4 bits wide; readLatency outside 1..15 is unsupported.
REQ-023 A write with addr at 2^addrSize-1 SHALL behave like any other address; there is no wrap or out-of-range handling.

Reset
REQ-024 rst_n=0 at a posedge: state IDLE (CLEAR with the macro), dataReady=0, dataOut=0, busy=0 (1 with the macro), protoErr=0, counter=0, rdAddr=0.
REQ-025 Reset asserted mid-read SHALL cancel the read with no dataReady pulse; reset takes priority over every transition.
REQ-026 Memory contents SHALL NOT be reset except by the CLEAR sequence.

Configuration
REQ-027 Macro RAM_RESPONDER_CLEAR_EN, when defined, SHALL compile in the CLEAR state: after reset, write 0 to mem[0]..mem[2^addrSize-1], one word per edge, with busy=1 and requests ignored; then go to IDLE.
REQ-028 Without RAM_RESPONDER_CLEAR_EN, reset goes directly to IDLE with busy=0, and memory retains prior or undefined contents.
REQ-029 With the macro, reset during CLEAR SHALL restart the clear from address 0.

Verification (ramWidth=8, addrSize=8, readLatency=3, macro off unless stated)
REQ-030 Write pulse addr=0x10 dataIn=0xA5; then hold read addr=0x10 -> dataReady high only in the 4th cycle after acceptance (edge k+3), dataOut=0xA5, busy low after READ_DONE.
REQ-031 RAMreadEnable held for 2 cycles after dataReady -> exactly one dataReady pulse and no second read started until RAMreadEnable returns to 0.
REQ-032 Read accepted, RAMreadEnable dropped after 1 cycle -> no dataReady, protoErr=1 and stays 1, dataOut unchanged.
REQ-033 Read of 0x20 (old 0x11) with a write of 0x22 to 0x20 on the completion edge -> dataOut=0x11; a following read -> 0x22.
REQ-034 rst_n=0 one cycle during READ_WAIT -> dataReady never pulses, all outputs 0, next read completes normally.
REQ-035 Macro on: release reset -> busy=1 for 256 cycles, then IDLE; a read of 0xFF returns 0x00.
